// File: rtl/hex_word_printer_pkg.sv
// hex_word_printer_pkg
// Shared definitions for the hex word printer:
//   - ASCII constants for the fixed characters it emits
//   - 3-bit FSM state encoding and the matching enum type
//   - cnt_width(): width of the nibble counter for a given nibble count
package hex_word_printer_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_X  = 8'h78;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PFX0  = 3'd1;
    localparam logic [2:0] ST_PFX1  = 3'd2;
    localparam logic [2:0] ST_DIGIT = 3'd3;
    localparam logic [2:0] ST_CR    = 3'd4;
    localparam logic [2:0] ST_LF    = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        PFX0  = ST_PFX0,
        PFX1  = ST_PFX1,
        DIGIT = ST_DIGIT,
        CR    = ST_CR,
        LF    = ST_LF
    } state_t;

    // clog2(nibbles), but never below 1 so a single-nibble word still
    // gets a legal (if unused) counter bit.
    function automatic int unsigned cnt_width(input int unsigned nibbles);
        int unsigned w;
        w = 32'd1;
        while ((32'd1 << w) < nibbles) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_word_printer_if.sv
// hex_word_printer_if
// Bundles the word-input and character-output handshakes of the printer.
//   word_valid/word_ready/word_data : producer -> printer word transfer
//   char_valid/char_ready/char_data/char_last : printer -> sink characters
//   busy : printer is in the middle of a word
// master = producer/sink side, slave = printer side.
interface hex_word_printer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  word_valid;
    logic                  word_ready;
    logic [DATA_WIDTH-1:0] word_data;
    logic                  char_valid;
    logic                  char_ready;
    logic [7:0]            char_data;
    logic                  char_last;
    logic                  busy;

    modport master (
        output word_valid, word_data, char_ready,
        input  word_ready, char_valid, char_data, char_last, busy
    );

    modport slave (
        input  word_valid, word_data, char_ready,
        output word_ready, char_valid, char_data, char_last, busy
    );
endinterface

// File: rtl/hex_to_ascii.sv
// hex_to_ascii
// Converts one 4-bit nibble into its uppercase ASCII hex digit.
//   nibble : input value 0..15
//   ascii  : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
module hex_to_ascii
    import hex_word_printer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Digits sit directly above '0'; letters are offset by 7 more to land on 'A'.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASC_0 + {4'h0, nibble};
        end else begin
            ascii = ASC_0 + 8'h07 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/hex_word_printer.sv
// hex_word_printer
// Captures a binary word and streams it out as ASCII hex, most significant
// nibble first, optionally wrapped with a "0x" prefix and a CR/LF suffix.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : slave side of hex_word_printer_if (word in, characters out, busy)
// Parameters: DATA_WIDTH (multiple of 4, >= 4), PREFIX_0X, APPEND_CRLF.
module hex_word_printer
    import hex_word_printer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter bit PREFIX_0X   = 1'b0,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    hex_word_printer_if.slave bus
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int CNT_W   = int'(cnt_width(NIBBLES));
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    state_t                state_r;
    state_t                state_s;
    logic [DATA_WIDTH-1:0] word_r;
    logic [DATA_WIDTH-1:0] word_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic                  char_valid_r;
    logic                  char_valid_s;
    logic [7:0]            char_data_r;
    logic [7:0]            char_data_s;
    logic                  char_last_r;
    logic                  char_last_s;
    logic                  busy_r;
    logic                  busy_s;
    logic                  xfer_s;
    logic [3:0]            nibble_s;
    logic [7:0]            hex_char_s;

    assign xfer_s = char_valid_r && bus.char_ready;

    // Next state, next word register and next nibble counter.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.word_valid) begin
                    word_s  = bus.word_data;
                    cnt_s   = CNT_LOAD;
                    state_s = PREFIX_0X ? PFX0 : DIGIT;
                end else begin
                    state_s = IDLE;
                end
            end
            PFX0: begin
                if (xfer_s) begin
                    state_s = PFX1;
                end else begin
                    state_s = PFX0;
                end
            end
            PFX1: begin
                if (xfer_s) begin
                    state_s = DIGIT;
                end else begin
                    state_s = PFX1;
                end
            end
            DIGIT: begin
                if (xfer_s) begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        state_s = APPEND_CRLF ? CR : IDLE;
                    end
                end else begin
                    state_s = DIGIT;
                end
            end
            CR: begin
                if (xfer_s) begin
                    state_s = LF;
                end else begin
                    state_s = CR;
                end
            end
            LF: begin
                if (xfer_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LF;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Nibble for the character that will be presented next cycle; looking at
    // the next word/counter lets a transfer be followed directly by its successor.
    assign nibble_s = word_s[{cnt_s, 2'b00} +: 4];

    hex_to_ascii u_hex_to_ascii (
        .nibble (nibble_s),
        .ascii  (hex_char_s)
    );

    // Character outputs for the next cycle, decoded from the next state.
    always_comb begin
        char_valid_s = 1'b0;
        char_data_s  = 8'h00;
        char_last_s  = 1'b0;
        case (state_s)
            IDLE: begin
                char_valid_s = 1'b0;
            end
            PFX0: begin
                char_valid_s = 1'b1;
                char_data_s  = ASC_0;
            end
            PFX1: begin
                char_valid_s = 1'b1;
                char_data_s  = ASC_X;
            end
            DIGIT: begin
                char_valid_s = 1'b1;
                char_data_s  = hex_char_s;
                char_last_s  = !APPEND_CRLF && (cnt_s == CNT_ZERO);
            end
            CR: begin
                char_valid_s = 1'b1;
                char_data_s  = ASC_CR;
            end
            LF: begin
                char_valid_s = 1'b1;
                char_data_s  = ASC_LF;
                char_last_s  = 1'b1;
            end
            default: begin
                char_valid_s = 1'b0;
            end
        endcase
    end

    assign busy_s = (state_s != IDLE);

    // State, captured word, counter and the registered character outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            word_r       <= {DATA_WIDTH{1'b0}};
            cnt_r        <= CNT_ZERO;
            char_valid_r <= 1'b0;
            char_data_r  <= 8'h00;
            char_last_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_r       <= word_s;
            cnt_r        <= cnt_s;
            char_valid_r <= char_valid_s;
            char_data_r  <= char_data_s;
            char_last_r  <= char_last_s;
            busy_r       <= busy_s;
        end
    end

    // Ready is a decode of the registered state, held low for as long as
    // reset is applied so no word can be offered into a block in reset.
    assign bus.word_ready = (state_r == IDLE) && !rst;
    assign bus.char_valid = char_valid_r;
    assign bus.char_data  = char_data_r;
    assign bus.char_last  = char_last_r;
    assign bus.busy       = busy_r;

endmodule

// File: doc/hex_word_printer.md
Name: hex_word_printer

Overview:
Sequencer that turns a captured binary word into a stream of ASCII hex characters, most significant nibble first, for a byte-wide character sink such as the UART TX. It steps the existing hex_to_ascii converter through one nibble per accepted character. It can optionally prepend "0x" and append CR/LF. The block sits between debug/status producers and the serial output path.

Parameters:
DATA_WIDTH, 32, width of the input word; must be a multiple of 4 and at least 4
PREFIX_0X, 0, 1 = emit '0','x' before the digits
APPEND_CRLF, 1, 1 = emit 0x0D, 0x0A after the last digit

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
word_valid  input  1  producer has a word
word_ready  output  1  block can accept a word
word_data  input  DATA_WIDTH  word to print
char_valid  output  1  char_data holds a valid character
char_ready  input  1  sink accepts the character
char_data  output  8  ASCII character
char_last  output  1  marks the final character of the current word
busy  output  1  a word is being printed

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst).
- Reset values: word_ready=0 while rst is high, then 1 in IDLE. char_valid=0, char_data=8'h00, char_last=0, busy=0, FSM=IDLE, nibble counter=0, word register=0.
- Reset asserted mid-word: the FSM returns to IDLE immediately. The partial word is discarded and nothing resumes.
- FSM states: IDLE, PFX0, PFX1, DIGIT, CR, LF.
- IDLE: word_ready=1 and busy=0. A transfer occurs on word_valid&&word_ready; word_data is latched at that edge. The next state is PFX0 if PREFIX_0X, otherwise DIGIT. The nibble counter loads NIBBLES-1, where NIBBLES=DATA_WIDTH/4.
- Latency: first char_valid is high in the cycle after the capture edge.
- word_ready=0 in every state except IDLE. word_valid while busy is ignored and holds no state.
- Output transfer: a character transfers on char_valid&&char_ready. char_valid stays high continuously from the first character to the last; there are no gaps while char_ready=1.
- Backpressure: while char_valid=1 and char_ready=0, char_data, char_last and the state hold stable.
- PFX0 emits 0x30 ('0'). PFX1 emits 0x78 ('x'). Each advances on transfer; PFX1 goes to DIGIT.
- DIGIT emits hex_to_ascii(word[4*cnt+3 : 4*cnt]). The mapping is 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46 (uppercase).
  - On transfer with cnt>0: decrement cnt.
  - On transfer with cnt==0: go to CR if APPEND_CRLF, otherwise IDLE.
- CR emits 0x0D and goes to LF on transfer. LF emits 0x0A and goes to IDLE on transfer.
- char_last=1 with the final character: LF if APPEND_CRLF, otherwise the cnt==0 digit.
- Characters per word = NIBBLES + 2*PREFIX_0X + 2*APPEND_CRLF.
- char_data, char_valid and char_last are registered outputs. The next character is precomputed so a transfer is followed directly by the next character.
- After the last-character transfer, char_valid=0 and the FSM is in IDLE the next cycle. With word_valid held high, the minimum word-to-word period is (characters per word + 1) cycles.
- busy=1 in all states except IDLE.

Decomposition:
- Shared package/header:
  - ASCII constants ASC_0=8'h30, ASC_X=8'h78, ASC_CR=8'h0D, ASC_LF=8'h0A.
  - FSM state encoding (3-bit localparams).
  - Nibble-count width function clog2(NIBBLES).
- Sub-module: the existing hex_to_ascii, instantiated once, fed by the nibble mux selected by the counter. No other sub-modules.

Test Plan:
- Defaults, word_data=32'h1234ABCD, char_ready=1 -> 10 consecutive characters "1234ABCD",0x0D,0x0A. char_last only on 0x0A; word_ready low for the whole stream.
- Backpressure: same word, char_ready=0 for 3 cycles while '3' is presented -> char_data holds 0x33 for all 4 cycles. The sequence is otherwise unchanged; no duplicated or skipped characters.
- DATA_WIDTH=8, PREFIX_0X=1, APPEND_CRLF=1, word 8'h0F -> "0x0F",0x0D,0x0A (6 characters). Repeat with APPEND_CRLF=0 -> "0x0F", char_last on 'F'.
- Second word_valid=1 with 32'hFFFFFFFF asserted while printing 32'h00000000 -> ignored until IDLE. It is captured only when word_ready=1 and prints after the first word's LF; no corruption of the first word.
- rst pulse during the 5th digit of 32'hDEADBEEF -> char_valid and busy drop asynchronously. After release, word_ready=1 and a new word 32'h00000009 prints "00000009",CR,LF cleanly.
- Back-to-back words with word_valid and char_ready held high -> each 10-character burst is separated by exactly one idle cycle (11-cycle period).
